// File: rtl/lemonde_streit_de2_led_pwm.sv
// ---------------------------------------------------------------------------
// lemonde_streit_de2_led_pwm
//
// LED output stage between the red-LED PIO out_port and the DE2 LEDR pins.
// Latches the PIO pattern once per PWM frame, applies 8-bit PWM dimming and
// optional frame-counted blinking, and exposes a 4-word Avalon-MM slave.
//
// Ports
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   address     Avalon-MM word address (0 CTRL, 1 DUTY, 2 BLINK, 3 STATUS)
//   chipselect  Avalon-MM select
//   write_n     Avalon-MM write strobe, active low
//   writedata   Avalon-MM write data
//   readdata    Avalon-MM read data, combinational from address
//   pattern_in  LED pattern from the PIO
//   led_out     registered LED drive
//
// Parameters
//   WIDTH     number of LED channels (at most 31, STATUS bit 31 is taken)
//   PRESCALE  clk cycles per PWM tick, >= 1
// ---------------------------------------------------------------------------
module lemonde_streit_de2_led_pwm #(
  parameter int WIDTH    = 18,
  parameter int PRESCALE = 196
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pattern_in,
  output logic [WIDTH-1:0] led_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Software-visible registers
  logic             enable;
  logic             blink_en;
  logic [7:0]       duty_req;
  logic [15:0]      blink_period;

  // Datapath state
  logic [PW-1:0]    presc_cnt;
  logic [7:0]       pwm_cnt;
  logic [15:0]      blink_cnt;
  logic             blink_phase;
  logic [WIDTH-1:0] pattern_shadow;
  logic [7:0]       duty_act;

  logic             wr_en;
  logic             tick;
  logic             frame_end;
  logic             blink_active;
  logic             pwm_on;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  assign wr_en = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable       <= 1'b0;
      blink_en     <= 1'b0;
      duty_req     <= 8'd0;
      blink_period <= 16'd0;
    end else if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          enable   <= writedata[0];
          blink_en <= writedata[1];
        end
        ADDR_DUTY:  duty_req     <= writedata[7:0];
        ADDR_BLINK: blink_period <= writedata[15:0];
        default: ;  // STATUS is read-only
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL: begin
        readdata[0] = enable;
        readdata[1] = blink_en;
      end
      ADDR_DUTY:  readdata[7:0]  = duty_req;
      ADDR_BLINK: readdata[15:0] = blink_period;
      ADDR_STATUS: begin
        readdata[WIDTH-1:0] = pattern_shadow;
        readdata[31]        = blink_phase;
      end
      default: readdata = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Prescaler and PWM frame counter
  // -------------------------------------------------------------------------
  assign tick      = enable && (presc_cnt == PRESC_MAX);
  assign frame_end = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= 8'd0;
    end else if (!enable) begin
      presc_cnt <= '0;
      pwm_cnt   <= 8'd0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Frame-synchronous shadows. While disabled they track continuously so an
  // enable starts from the current pattern and duty instead of stale values.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_shadow <= '0;
      duty_act       <= 8'd0;
    end else if (!enable || frame_end) begin
      pattern_shadow <= pattern_in;
      duty_act       <= duty_req;
    end
  end

  // -------------------------------------------------------------------------
  // Blink. The >= compare makes a period shrunk below the running count
  // toggle on the next frame_end rather than waiting for a 16-bit wrap.
  // -------------------------------------------------------------------------
  assign blink_active = enable && blink_en && (blink_period != 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (!blink_active) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt >= (blink_period - 16'd1)) begin
        blink_cnt   <= 16'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output gate. Duty 255 is forced fully on so there is no 1/256 dropout.
  // -------------------------------------------------------------------------
  assign pwm_on = (duty_act == 8'hFF) || (pwm_cnt < duty_act);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= pattern_shadow & {WIDTH{pwm_on && blink_phase && enable}};
    end
  end

endmodule

// File: tb/tb_lemonde_streit_de2_led_pwm.sv
module tb_lemonde_streit_de2_led_pwm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [17:0] pattern_in = 18'd0;
  logic [17:0] led_out;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  lemonde_streit_de2_led_pwm #(.WIDTH(18), .PRESCALE(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pattern_in (pattern_in),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Returns at the falling edge following the capturing rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] want);
    address = a;
    #1;
    check(tag, readdata, want);
  endtask

  // One cycle: wait for the next falling edge, pop and compare.
  task automatic step_led(input string tag);
    logic [17:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {14'd0, led_out}, {14'd0, e});
    end
  endtask

  // Cycle k after the enabling edge shows pwm_cnt = (k-1) mod 256.
  function automatic logic [17:0] pwm_exp(input int k, input int duty, input logic [17:0] pat);
    int c;
    c = (k - 1) % 256;
    if (duty == 255 || c < duty) return pat;
    return 18'd0;
  endfunction

  task automatic restart(input logic [31:0] duty, input logic [31:0] ctrl);
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, duty);
    bus_write(2'd0, ctrl);
  endtask

  initial begin
    // Reset state
    #12;
    read_check("rst_ctrl",   2'd0, 32'd0);
    read_check("rst_duty",   2'd1, 32'd0);
    read_check("rst_blink",  2'd2, 32'd0);
    read_check("rst_status", 2'd3, 32'h8000_0000);
    check("rst_led", {14'd0, led_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Register readback and masking
    bus_write(2'd0, 32'hFFFF_FFFC);
    read_check("ctrl_mask", 2'd0, 32'd0);
    bus_write(2'd1, 32'h1234_56C3);
    read_check("duty_rd", 2'd1, 32'h0000_00C3);
    bus_write(2'd2, 32'hABCD_0007);
    read_check("blink_rd", 2'd2, 32'h0000_0007);
    bus_write(2'd3, 32'h0003_FFFF);
    read_check("status_ro", 2'd3, 32'h8000_0000);
    bus_write(2'd2, 32'd0);

    // Duty 64 over three frames
    pattern_in = 18'h3FFFF;
    restart(32'd64, 32'd1);
    for (int k = 1; k <= 768; k++) exp_q.push_back(pwm_exp(k, 64, 18'h3FFFF));
    for (int k = 1; k <= 768; k++) step_led("duty64");

    // Duty 0: always off
    restart(32'd0, 32'd1);
    for (int k = 1; k <= 768; k++) exp_q.push_back(18'd0);
    for (int k = 1; k <= 768; k++) step_led("duty0");

    // Duty 255: always on
    pattern_in = 18'h2AAAA;
    restart(32'd255, 32'd1);
    for (int k = 1; k <= 768; k++) exp_q.push_back(18'h2AAAA);
    for (int k = 1; k <= 768; k++) step_led("duty255");

    // Pattern change mid-frame: takes effect at frame_end (edge 256)
    pattern_in = 18'h00001;
    restart(32'd255, 32'd1);
    address = 2'd3;
    for (int k = 1; k <= 400; k++) exp_q.push_back((k <= 256) ? 18'h00001 : 18'h20000);
    for (int k = 1; k <= 400; k++) begin
      step_led("pat_chg");
      if (k == 100) pattern_in = 18'h20000;
      if (k == 255) begin #1; check("pat_status_old", readdata, 32'h8000_0001); end
      if (k == 256) begin #1; check("pat_status_new", readdata, 32'h8002_0000); end
    end

    // Blink every 2 frames
    pattern_in = 18'h2AAAA;
    bus_write(2'd0, 32'd0);
    bus_write(2'd2, 32'd2);
    restart(32'd255, 32'd3);
    address = 2'd3;
    for (int k = 1; k <= 1536; k++)
      exp_q.push_back((((k - 1) / 512) % 2 == 0) ? 18'h2AAAA : 18'd0);
    for (int k = 1; k <= 1536; k++) begin
      step_led("blink");
      if (k == 100)  begin #1; check("blink_ph_100",  {31'd0, readdata[31]}, 32'd1); end
      if (k == 511)  begin #1; check("blink_ph_511",  {31'd0, readdata[31]}, 32'd1); end
      if (k == 512)  begin #1; check("blink_ph_512",  {31'd0, readdata[31]}, 32'd0); end
      if (k == 1023) begin #1; check("blink_ph_1023", {31'd0, readdata[31]}, 32'd0); end
      if (k == 1024) begin #1; check("blink_ph_1024", {31'd0, readdata[31]}, 32'd1); end
    end

    // Asynchronous reset mid-frame
    bus_write(2'd2, 32'd0);
    restart(32'd255, 32'd1);
    for (int k = 1; k <= 50; k++) exp_q.push_back(18'h2AAAA);
    for (int k = 1; k <= 50; k++) step_led("pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_led", {14'd0, led_out}, 32'd0);
    read_check("async_ctrl", 2'd0, 32'd0);
    read_check("async_duty", 2'd1, 32'd0);
    #2;
    reset_n = 1'b1;
    for (int k = 1; k <= 300; k++) exp_q.push_back(18'd0);
    for (int k = 1; k <= 300; k++) step_led("post_rst");
    read_check("post_status", 2'd3, 32'h8002_AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
